// File: rtl/seq_mult_param.sv
// Parametrised sequential shift-add multiplier with runtime signed/unsigned mode.
// Signed operands are reduced to magnitudes, multiplied, then the sign is reapplied on completion.
module seq_mult_param #(
   parameter int  DW         = 8,
   parameter int  EARLY_EXIT = 1,
   localparam int D2W        = 2 * DW
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           signed_mode,
   input  logic [DW-1:0]  multiplicand,
   input  logic [DW-1:0]  multiplier,
   output logic [D2W-1:0] product,
   output logic           ready,
   output logic           done
);

   localparam int             CW      = (DW > 2) ? $clog2(DW) : 1;
   localparam logic           EE_ON   = (EARLY_EXIT != 0);
   localparam logic [DW-1:0]  ZERO_DW = {DW{1'b0}};
   localparam logic [DW-1:0]  ONE_DW  = {{(DW-1){1'b0}}, 1'b1};
   localparam logic [D2W-1:0] ZERO_PW = {D2W{1'b0}};
   localparam logic [D2W-1:0] ONE_PW  = {{(D2W-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]  LAST_CNT = CW'(DW - 1);
   localparam logic [CW-1:0]  ONE_CNT  = {{(CW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      INIT      = 2'd1,
      ADD_SHIFT = 2'd2,
      DONE      = 2'd3
   } state_t;

   // The most negative input maps to 2^(DW-1), which still fits in DW unsigned bits.
   function automatic logic [DW-1:0] magnitude(input logic [DW-1:0] x, input logic is_signed);
      logic [DW-1:0] m;
      if (is_signed && x[DW-1]) begin
         m = ~x + ONE_DW;
      end else begin
         m = x;
      end
      return m;
   endfunction

   state_t         state_r, state_s;
   logic [DW-1:0]  op_a_r, op_b_r;
   logic           smode_r;
   logic [D2W-1:0] mcand_r;
   logic [DW-1:0]  mlr_r;
   logic [D2W-1:0] acc_r;
   logic [CW-1:0]  cnt_r;
   logic           sign_r;
   logic [D2W-1:0] product_r;
   logic           ready_r, done_r;

   logic [DW-1:0]  mag_a_s, mag_b_s;
   logic [D2W-1:0] acc_sum_s, result_s;
   logic [DW-1:0]  mlr_rest_s;
   logic           last_iter_s;

   // Datapath arithmetic for the current iteration and the final signed result.
   always_comb begin
      mag_a_s     = magnitude(op_a_r, smode_r);
      mag_b_s     = magnitude(op_b_r, smode_r);
      mlr_rest_s  = mlr_r >> 1;
      if (mlr_r[0]) begin
         acc_sum_s = acc_r + mcand_r;
      end else begin
         acc_sum_s = acc_r;
      end
      if (sign_r) begin
         result_s = ~acc_sum_s + ONE_PW;
      end else begin
         result_s = acc_sum_s;
      end
      last_iter_s = (cnt_r == LAST_CNT) || (EE_ON && (mlr_rest_s == ZERO_DW));
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = INIT;
            end else begin
               state_s = IDLE;
            end
         end
         INIT: begin
            if (EE_ON && (mag_b_s == ZERO_DW)) begin
               state_s = DONE;
            end else begin
               state_s = ADD_SHIFT;
            end
         end
         ADD_SHIFT: begin
            if (last_iter_s) begin
               state_s = DONE;
            end else begin
               state_s = ADD_SHIFT;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register with handshake outputs registered from the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
         ready_r <= 1'b1;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         ready_r <= (state_s == IDLE);
         done_r  <= (state_s == DONE);
      end
   end

   // Operand capture, shift-add iteration and product update on DONE entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_a_r    <= ZERO_DW;
         op_b_r    <= ZERO_DW;
         smode_r   <= 1'b0;
         mcand_r   <= ZERO_PW;
         mlr_r     <= ZERO_DW;
         acc_r     <= ZERO_PW;
         cnt_r     <= {CW{1'b0}};
         sign_r    <= 1'b0;
         product_r <= ZERO_PW;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  op_a_r  <= multiplicand;
                  op_b_r  <= multiplier;
                  smode_r <= signed_mode;
               end
            end
            INIT: begin
               mcand_r <= {ZERO_DW, mag_a_s};
               mlr_r   <= mag_b_s;
               acc_r   <= ZERO_PW;
               cnt_r   <= {CW{1'b0}};
               sign_r  <= smode_r & (op_a_r[DW-1] ^ op_b_r[DW-1]);
               // Early exit straight from INIT: the accumulator is zero, so the product is zero.
               if (state_s == DONE) begin
                  product_r <= ZERO_PW;
               end
            end
            ADD_SHIFT: begin
               acc_r   <= acc_sum_s;
               mcand_r <= mcand_r << 1;
               mlr_r   <= mlr_rest_s;
               cnt_r   <= cnt_r + ONE_CNT;
               if (last_iter_s) begin
                  product_r <= result_s;
               end
            end
            DONE: begin
               cnt_r <= cnt_r;
            end
            default: begin
               cnt_r <= {CW{1'b0}};
            end
         endcase
      end
   end

   assign product = product_r;
   assign ready   = ready_r;
   assign done    = done_r;

endmodule
